rc4_decrypt: RTL and testbench

// RC4 decryption engine; the stage launched by the MCU's RC4_start and reporting back on RC4_done.
// - Builds the 256-byte S-box from a fixed-length key (init + KSA), then runs PRGA.
// - XORs the keystream with a ciphertext byte stream (valid/ready in, valid/ready out).
// - Holds RC4_done high once NUM_BYTES plaintext bytes have been delivered.
//

---
 rtl/rc4_decrypt.sv | 171 +++++++++++++++++
 tb/tb_rc4_decrypt.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt.sv
// RC4 decryption engine: builds the S-box from the key, then XORs the PRGA keystream onto a byte stream.
// Optional keystream discard stage (DROP_N bytes) is compiled in when RC4_DROP_EN is defined.
module rc4_decrypt #(
  parameter int KEY_LEN   = 3,
  parameter int NUM_BYTES = 1024,
  parameter int DROP_N    = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RC4_start,
  input  logic [8*KEY_LEN-1:0] key,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic                 RC4_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_KSA    = 3'd2;
`ifdef RC4_DROP_EN
  localparam logic [2:0] S_DROP   = 3'd3;
`endif
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  if (KEY_LEN < 1 || KEY_LEN > 32) begin : g_bad_key_len
    $error("rc4_decrypt: KEY_LEN must be 1..32");
  end
  if (NUM_BYTES < 1) begin : g_bad_num_bytes
    $error("rc4_decrypt: NUM_BYTES must be >= 1");
  end
  if (DROP_N < 0) begin : g_bad_drop_n
    $error("rc4_decrypt: DROP_N must be >= 0");
  end

  logic [2:0]    state;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [KW-1:0] kidx;
  logic [CW-1:0] count;
  logic [7:0]    s_box [256];
  logic [7:0]    key_bytes [KEY_LEN];

  for (genvar k = 0; k < KEY_LEN; k++) begin : g_key
    assign key_bytes[k] = key[8*k +: 8];
  end

  logic [7:0] ksa_si, ksa_j, ksa_sj;
  logic [7:0] p_i, p_si, p_j, p_sj, p_t, ks;

  // ks must reflect the swap done in the same cycle, so the two swapped slots are forwarded
  always_comb begin
    ksa_si = s_box[i];
    ksa_j  = j + ksa_si + key_bytes[kidx];
    ksa_sj = s_box[ksa_j];
    p_i    = i + 8'd1;
    p_si   = s_box[p_i];
    p_j    = j + p_si;
    p_sj   = s_box[p_j];
    p_t    = p_si + p_sj;
    if (p_t == p_i)
      ks = p_sj;
    else if (p_t == p_j)
      ks = p_si;
    else
      ks = s_box[p_t];
  end

  logic accept;
  logic prga_step;

  assign in_ready = (state == S_STREAM) && (count != CW'(NUM_BYTES)) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign RC4_done = (state == S_DONE);

`ifdef RC4_DROP_EN
  localparam int DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
  logic [DW-1:0] drop_cnt;
  assign prga_step = accept || (state == S_DROP);
`else
  assign prga_step = accept;
`endif

  // S-box contents are don't-care after reset, so it carries no reset
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      for (int n = 0; n < 256; n++) s_box[n] <= 8'(n);
    end else if (state == S_KSA) begin
      s_box[i]     <= ksa_sj;
      s_box[ksa_j] <= ksa_si;
    end else if (prga_step) begin
      s_box[p_i] <= p_sj;
      s_box[p_j] <= p_si;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      i         <= 8'd0;
      j         <= 8'd0;
      kidx      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
`ifdef RC4_DROP_EN
      drop_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (RC4_start) state <= S_INIT;
        S_INIT: begin
          i     <= 8'd0;
          j     <= 8'd0;
          kidx  <= '0;
          count <= '0;
          state <= S_KSA;
        end
        S_KSA: begin
          i    <= i + 8'd1;
          j    <= ksa_j;
          kidx <= (kidx == KW'(KEY_LEN - 1)) ? '0 : kidx + KW'(1);
          if (i == 8'd255) begin
            i <= 8'd0;
            j <= 8'd0;
`ifdef RC4_DROP_EN
            if (DROP_N == 0) begin
              state <= S_STREAM;
            end else begin
              state    <= S_DROP;
              drop_cnt <= DW'(DROP_N);
            end
`else
            state <= S_STREAM;
`endif
          end
        end
`ifdef RC4_DROP_EN
        S_DROP: begin
          i        <= p_i;
          j        <= p_j;
          drop_cnt <= drop_cnt - DW'(1);
          if (drop_cnt == DW'(1)) state <= S_STREAM;
        end
`endif
        S_STREAM: begin
          if (accept) begin
            i         <= p_i;
            j         <= p_j;
            out_data  <= in_data ^ ks;
            out_valid <= 1'b1;
            count     <= count + CW'(1);
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (count == CW'(NUM_BYTES)) state <= S_DONE;
          end
        end
        S_DONE: if (RC4_start) state <= S_INIT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Self-checking bench for rc4_decrypt: known "Key"/"Plaintext" vectors plus random runs against a software RC4 model.
module tb_rc4_decrypt;
  localparam int KEY_LEN   = 3;
  localparam int NUM_BYTES = 9;
  localparam int DROP_N    = 256;
`ifdef RC4_DROP_EN
  localparam int DROP        = DROP_N;
  localparam int FIRST_READY = 514;
`else
  localparam int DROP        = 0;
  localparam int FIRST_READY = 258;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RC4_start = 1'b0;
  logic [23:0] key = 24'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, RC4_done;
  logic [7:0]  out_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] ct;
    logic [7:0] pt;
  } vec_t;
  vec_t       vecs [NUM_BYTES];
  logic [7:0] ct_arr [NUM_BYTES];
  logic [7:0] ks_arr [NUM_BYTES];
  logic [7:0] got_q [$];

  always #5 clk = ~clk;

  rc4_decrypt #(.KEY_LEN(KEY_LEN), .NUM_BYTES(NUM_BYTES), .DROP_N(DROP_N)) dut (
    .clk(clk), .rst(rst), .RC4_start(RC4_start), .key(key),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .RC4_done(RC4_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain software RC4: KSA over the key, discard DROP bytes, keep NUM_BYTES keystream bytes
  task automatic model_ks(input logic [23:0] k);
    int s [256];
    int a, b, tmp, kb;
    for (int n = 0; n < 256; n++) s[n] = n;
    b = 0;
    for (int n = 0; n < 256; n++) begin
      kb  = int'((k >> (8 * (n % KEY_LEN))) & 24'hFF);
      b   = (b + s[n] + kb) % 256;
      tmp = s[n]; s[n] = s[b]; s[b] = tmp;
    end
    a = 0; b = 0;
    for (int n = 0; n < DROP + NUM_BYTES; n++) begin
      a   = (a + 1) % 256;
      b   = (b + s[a]) % 256;
      tmp = s[a]; s[a] = s[b]; s[b] = tmp;
      if (n >= DROP) ks_arr[n - DROP] = 8'(s[(s[a] + s[b]) % 256]);
    end
  endtask

  task automatic start_and_wait(input logic [23:0] k, input int pulse_at, output int lat);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    key       = k;
    RC4_start = 1'b1;
    @(posedge clk);
    #1 RC4_start = 1'b0;
    lat = 1;
    @(negedge clk);
    check("done_cleared_on_start", RC4_done, 1'b0);
    while (!in_ready && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      RC4_start = (lat == pulse_at);
      @(negedge clk);
    end
    RC4_start = 1'b0;
  endtask

  // mode 0: full rate; 1: 5-cycle output stall after first byte; 2: random throttling; 3: full rate + stray start
  task automatic stream(input int n, input int mode, output int iters);
    int idx, stall_left;
    logic stalled_once, holding;
    logic [7:0] held;
    idx = 0; stall_left = 0; stalled_once = 1'b0; holding = 1'b0; held = 8'd0;
    iters = 0;
    got_q.delete();
    while (got_q.size() < n && iters < 2000) begin
      @(negedge clk);
      case (mode)
        1: begin
          if (!stalled_once && got_q.size() >= 1) begin
            stall_left   = 5;
            stalled_once = 1'b1;
          end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
          in_valid = 1'b1;
        end
        2: begin
          out_ready = ($urandom_range(0, 3) != 0);
          in_valid  = ($urandom_range(0, 3) != 0);
        end
        default: begin
          out_ready = 1'b1;
          in_valid  = 1'b1;
        end
      endcase
      RC4_start = (mode == 3 && iters == 3);
      in_data   = (idx < n) ? ct_arr[idx] : 8'hA5;
      #1;
      if (holding) begin
        check("stall_hold_valid", out_valid, 1'b1);
        check("stall_hold_data", out_data, held);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 1'b0);
        held    = out_data;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (idx >= n) check("extra_accept", 1'b1, 1'b0);
        idx++;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      iters++;
    end
    RC4_start = 1'b0;
    if (iters >= 2000) check("stream_timeout", 1'b1, 1'b0);
  endtask

  task automatic compare_model(input string nm);
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k < got_q.size()) check(nm, got_q[k], ct_arr[k] ^ ks_arr[k]);
      else check({nm, "_missing"}, 1'b1, 1'b0);
    end
  endtask

  task automatic check_done_tail();
    logic bad;
    check("done_early", RC4_done, 1'b0);
    @(negedge clk);
    check("done_rise", RC4_done, 1'b1);
    check("done_out_valid", out_valid, 1'b0);
    check("done_in_ready", in_ready, 1'b0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (in_ready || out_valid || !RC4_done) bad = 1'b1;
    end
    check("done_hold", bad, 1'b0);
  endtask

  initial begin
    int lat, iters;
    logic bad;

    // reset state
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_done", RC4_done, 1'b0);
    @(negedge clk) rst = 1'b0;

    // reset in the middle of KSA
    @(negedge clk);
    key = 24'h79654B;
    RC4_start = 1'b1;
    @(negedge clk) RC4_start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ksa_rst_in_ready", in_ready, 1'b0);
    check("ksa_rst_out_valid", out_valid, 1'b0);
    check("ksa_rst_out_data", out_data, 8'h00);
    check("ksa_rst_done", RC4_done, 1'b0);
    @(negedge clk) rst = 1'b0;
    bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (in_ready || out_valid || RC4_done) bad = 1'b1;
    end
    check("idle_after_rst", bad, 1'b0);

    // known vector: key "Key", ciphertext -> "Plaintext"
    vecs[0] = '{8'hBB, 8'h50}; vecs[1] = '{8'hF3, 8'h6C}; vecs[2] = '{8'h16, 8'h61};
    vecs[3] = '{8'hE8, 8'h69}; vecs[4] = '{8'hD9, 8'h6E}; vecs[5] = '{8'h40, 8'h74};
    vecs[6] = '{8'hAF, 8'h65}; vecs[7] = '{8'h0A, 8'h78}; vecs[8] = '{8'hD3, 8'h74};
    model_ks(24'h79654B);
    for (int k = 0; k < NUM_BYTES; k++) begin
      ct_arr[k] = vecs[k].ct;
`ifdef RC4_DROP_EN
      vecs[k].pt = vecs[k].ct ^ ks_arr[k];
`endif
    end

    start_and_wait(24'h79654B, 0, lat);
    check("first_ready_latency", lat, FIRST_READY);
    stream(NUM_BYTES, 0, iters);
    check("b2b_cycles", iters, NUM_BYTES + 1);
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k < got_q.size()) check("vec_plain", got_q[k], vecs[k].pt);
      else check("vec_missing", 1'b1, 1'b0);
    end
    check_done_tail();

    // restart from DONE with a stalled output after the first byte
    start_and_wait(24'h79654B, 0, lat);
    check("restart_latency", lat, FIRST_READY);
    stream(NUM_BYTES, 1, iters);
    check("stall_cycles", iters, NUM_BYTES + 6);
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k < got_q.size()) check("stall_plain", got_q[k], vecs[k].pt);
      else check("stall_missing", 1'b1, 1'b0);
    end
    check_done_tail();

    // stray RC4_start pulses during KSA and STREAM
    start_and_wait(24'h79654B, 100, lat);
    check("pulse_ksa_latency", lat, FIRST_READY);
    stream(NUM_BYTES, 3, iters);
    check("pulse_stream_cycles", iters, NUM_BYTES + 1);
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k < got_q.size()) check("pulse_plain", got_q[k], vecs[k].pt);
      else check("pulse_missing", 1'b1, 1'b0);
    end
    check_done_tail();

    // random keys, ciphertext and handshake throttling
    repeat (5) begin
      logic [23:0] rk;
      rk = 24'($urandom);
      for (int k = 0; k < NUM_BYTES; k++) ct_arr[k] = 8'($urandom);
      model_ks(rk);
      start_and_wait(rk, 0, lat);
      check("rand_latency", lat, FIRST_READY);
      stream(NUM_BYTES, 2, iters);
      compare_model("rand_plain");
      check_done_tail();
    end

    // reset with a pending output byte
    model_ks(24'h79654B);
    for (int k = 0; k < NUM_BYTES; k++) ct_arr[k] = vecs[k].ct;
    start_and_wait(24'h79654B, 0, lat);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = ct_arr[0];
    @(negedge clk);
    in_valid = 1'b0;
    check("pending_valid", out_valid, 1'b1);
    check("pending_data", out_data, vecs[0].pt);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_data", out_data, 8'h00);
    check("abort_done", RC4_done, 1'b0);
    @(negedge clk) rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready || out_valid || RC4_done) bad = 1'b1;
    end
    check("abort_quiet", bad, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
